neander_mem_arbiter: RTL and testbench
======================================

Name: neander_mem_arbiter

Overview:
- Shares the single-port program/data RAM between the NEANDER-X CPU and a secondary requester (UART program loader / debug port).
- Sits between cpu_top's memory interface and the RAM.
- Gives the CPU priority. Serves the loader in CPU-idle cycles.
- Freezes the CPU through cpu_stall when the loader is starved, or for the whole duration of a bulk-load hold.

Parameters:
- MAX_WAIT, 4: max consecutive cycles a pending loader request may be refused before the CPU is stalled for one cycle; legal range 1..15.
- STAT_W, 16: width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- cpu_addr  in  8  CPU memory address
- cpu_wdata  in  8  CPU write data
- cpu_read  in  1  CPU read strobe
- cpu_write  in  1  CPU write strobe
- cpu_rdata  out  8  read data to CPU; combinational from ram_rdata
- cpu_stall  out  1  CPU clock-enable inhibit; CPU holds all state while high
- ld_req  in  1  loader access request; held until granted
- ld_we  in  1  loader access is a write (qualifies ld_req)
- ld_addr  in  8  loader address
- ld_wdata  in  8  loader write data
- ld_hold  in  1  loader requests continuous CPU halt (bulk programming)
- ld_gnt  out  1  combinational; access performed this cycle
- ld_rvalid  out  1  registered; loader read data valid, one cycle after a granted read
- ld_rdata  out  8  registered loader read data
- ram_addr  out  8  RAM address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write enable (write on clk edge)
- ram_re  out  1  RAM read enable (combinational read)
- ram_rdata  in  8  RAM read data
- stat_grants  out  STAT_W  loader grant count (optional feature)
- stat_stalls  out  STAT_W  CPU stall-cycle count (optional feature)

Behaviour:
- Reset (reset=0 at clk edge):
  - state=CPU_OWN, wait_cnt=0.
  - ld_rvalid=0, ld_rdata=0, stats=0.
  - cpu_stall=0 while in CPU_OWN.
- FSM states: CPU_OWN, LD_SLOT, HALT.
- CPU_OWN:
  - cpu_stall=0.
  - If cpu_read|cpu_write: RAM driven from the CPU; ld_gnt=0.
  - Else if ld_req: RAM driven from the loader; ld_gnt=1 (same-cycle service).
  - wait_cnt increments on each cycle with ld_req=1 and ld_gnt=0; clears on grant or when ld_req=0.
  - Transitions, priority as listed:
    - ld_hold=1 → HALT.
    - Else wait_cnt==MAX_WAIT-1 with the request refused this cycle → LD_SLOT.
    - Else stay.
- LD_SLOT:
  - cpu_stall=1, RAM driven from the loader.
  - ld_gnt=ld_req; if ld_req=0, no access (ram_we=ram_re=0).
  - wait_cnt cleared.
  - Next state: HALT if ld_hold=1, else CPU_OWN.
- HALT:
  - cpu_stall=1 every cycle.
  - Loader owns the RAM: ld_gnt=ld_req.
  - ld_hold=0 → CPU_OWN next cycle; cpu_stall drops that same next cycle.
- RAM mux:
  - ram_addr, ram_wdata, ram_we, ram_re come from the current owner.
  - CPU owner: ram_we=cpu_write, ram_re=cpu_read.
  - Loader owner: ram_we=ld_gnt&ld_we, ram_re=ld_gnt&~ld_we.
  - Non-owner strobes are gated to 0. ram_addr is don't-care when both strobes are 0 and is driven to 0.
- CPU read and write both high: both forwarded unchanged; the RAM defines the result (illegal, no checking here).
- Loader read return:
  - On a granted read, ld_rdata<=ram_rdata and ld_rvalid<=1 at the next edge.
  - Otherwise ld_rvalid<=0; ld_rdata holds its value.
- cpu_rdata=ram_rdata unconditionally. The CPU samples it only when it is not stalled and is the owner.
- Reset during HALT/LD_SLOT: returns to CPU_OWN and drops stall. A granted loader read in flight is discarded (ld_rvalid=0).
- wait_cnt is $clog2(MAX_WAIT+1) bits and never exceeds MAX_WAIT-1.

Optional Feature:
- Macro: NEANDER_MEM_ARB_STATS_EN.
- Defined:
  - stat_grants increments on every ld_gnt=1 cycle.
  - stat_stalls increments on every cpu_stall=1 cycle.
  - Both saturate at all-ones and clear on reset.
- Undefined: both outputs tied to 0; no counter flops exist.

Decomposition:
- Package neander_pkg:
  - typedef enum logic [1:0] arb_state_t {CPU_OWN, LD_SLOT, HALT}.
  - Localparams for data/address width (8).
- One natural sub-module: neander_sat_counter (STAT_W-bit saturating increment). Instantiated twice under the macro.
- FSM and mux remain in the top.

Test Plan:
- Idle CPU: ld_req=1, ld_we=1, ld_addr=0x80, ld_wdata=0x5A, cpu strobes 0 → ld_gnt=1 same cycle, ram_we=1, ram_addr=0x80; a later loader read of 0x80 gives ld_rvalid=1, ld_rdata=0x5A one cycle after the grant.
- Starvation, MAX_WAIT=4: CPU reads every cycle while ld_req=1 → 4 refused cycles, then one LD_SLOT cycle with cpu_stall=1 and ld_gnt=1; CPU resumes the next cycle with wait_cnt=0.
- Bulk load: ld_hold=1 for 10 cycles with a loader write each cycle (addr 0x00..0x09) → cpu_stall=1 from the cycle after ld_hold rises until one cycle after it falls; all 10 writes reach the RAM, with no CPU strobe reaching it.
- Contention: cpu_write=1 (addr 0x10) and ld_req=1 in the same cycle → ram_addr=0x10 from the CPU, ld_gnt=0, wait_cnt=1.
- Reset mid-HALT: drive reset=0 during HALT with a granted read pending → next cycle state CPU_OWN, cpu_stall=0, ld_rvalid=0.
- With NEANDER_MEM_ARB_STATS_EN defined and STAT_W=4: 20 grant cycles → stat_grants=15 (saturated); stat_stalls equals the counted stall cycles.

Source files
------------

// File: rtl/neander_pkg.sv
// Shared definitions for the NEANDER-X memory arbiter.
//   DATA_W / ADDR_W : RAM data and address widths
//   arb_state_t     : arbiter ownership states
package neander_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        LD_SLOT = 2'd1,
        HALT    = 2'd2
    } arb_state_t;

endpackage

// File: rtl/neander_sat_counter.sv
// Saturating up-counter used for arbiter statistics.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-low reset, clears the count
//   inc   : increment request for this cycle
//   count : current count, sticks at all-ones
module neander_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/neander_mem_arbiter.sv
// Arbiter sharing the single-port program/data RAM between the NEANDER-X CPU and a
// secondary requester (UART loader / debug port). The CPU has priority; the loader
// is served in CPU-idle cycles, in a forced one-cycle slot after MAX_WAIT refusals,
// or continuously while it holds ld_hold (CPU frozen via cpu_stall).
// Ports:
//   clk, reset               : clock and synchronous active-low reset
//   cpu_addr/wdata/read/write: CPU memory interface; cpu_rdata returned from RAM
//   cpu_stall                : CPU clock-enable inhibit
//   ld_req/we/addr/wdata     : loader request (held until ld_gnt)
//   ld_hold                  : loader bulk-programming halt request
//   ld_gnt                   : loader access performed this cycle
//   ld_rvalid/ld_rdata       : registered loader read return
//   ram_*                    : RAM port (write on edge, combinational read)
//   stat_grants/stat_stalls  : statistics, only with NEANDER_MEM_ARB_STATS_EN defined
// Optional feature macro: NEANDER_MEM_ARB_STATS_EN (saturating grant/stall counters).
module neander_mem_arbiter
    import neander_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_hold,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [STAT_W-1:0] stat_grants,
    output logic [STAT_W-1:0] stat_stalls
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              cpu_access;
    logic              cpu_owner;
    logic              ld_owner;
    logic              refused;

    assign cpu_access = cpu_read | cpu_write;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CPU_OWN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        cpu_stall = 1'b0;
        ld_gnt    = 1'b0;
        cpu_owner = 1'b0;
        ld_owner  = 1'b0;
        refused   = 1'b0;
        unique case (state_q)
            CPU_OWN: begin
                if (cpu_access) begin
                    cpu_owner = 1'b1;
                end else if (ld_req) begin
                    ld_owner = 1'b1;
                    ld_gnt   = 1'b1;
                end
                refused = ld_req & cpu_access;
                // Counter wraps to 0 on the forced-slot transition so it never
                // reaches MAX_WAIT.
                if (refused && (wait_q != WAIT_LAST)) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
                if (ld_hold) begin
                    state_d = HALT;
                end else if (refused && (wait_q == WAIT_LAST)) begin
                    state_d = LD_SLOT;
                end
            end
            LD_SLOT: begin
                cpu_stall = 1'b1;
                ld_owner  = 1'b1;
                ld_gnt    = ld_req;
                state_d   = ld_hold ? HALT : CPU_OWN;
            end
            HALT: begin
                cpu_stall = 1'b1;
                ld_owner  = 1'b1;
                ld_gnt    = ld_req;
                if (!ld_hold) begin
                    state_d = CPU_OWN;
                end
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    // RAM port mux; address/data parked at 0 when no access is performed.
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        if (cpu_owner) begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_we    = cpu_write;
            ram_re    = cpu_read;
        end else if (ld_owner && ld_gnt) begin
            ram_addr  = ld_addr;
            ram_wdata = ld_wdata;
            ram_we    = ld_we;
            ram_re    = ~ld_we;
        end
    end

    assign cpu_rdata = ram_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ld_rvalid <= 1'b0;
            ld_rdata  <= '0;
        end else begin
            ld_rvalid <= ld_gnt & ~ld_we;
            if (ld_gnt && !ld_we) begin
                ld_rdata <= ram_rdata;
            end
        end
    end

`ifdef NEANDER_MEM_ARB_STATS_EN
    neander_sat_counter #(
        .WIDTH(STAT_W)
    ) u_grant_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (ld_gnt),
        .count(stat_grants)
    );

    neander_sat_counter #(
        .WIDTH(STAT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (cpu_stall),
        .count(stat_stalls)
    );
`else
    assign stat_grants = '0;
    assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_neander_mem_arbiter.sv
// Self-checking bench for neander_mem_arbiter. A behavioural RAM is attached to the
// RAM port; expected RAM writes and loader read returns are queued by the stimulus
// and checked by an independent monitor. Cycle-level strobes are checked inline.
module tb_neander_mem_arbiter;

    localparam int unsigned MAX_WAIT = 4;
    localparam int unsigned STAT_W   = 4;

    logic              clk;
    logic              reset;
    logic [7:0]        cpu_addr;
    logic [7:0]        cpu_wdata;
    logic              cpu_read;
    logic              cpu_write;
    logic [7:0]        cpu_rdata;
    logic              cpu_stall;
    logic              ld_req;
    logic              ld_we;
    logic [7:0]        ld_addr;
    logic [7:0]        ld_wdata;
    logic              ld_hold;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [7:0]        ld_rdata;
    logic [7:0]        ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic              ram_re;
    logic [7:0]        ram_rdata;
    logic [STAT_W-1:0] stat_grants;
    logic [STAT_W-1:0] stat_stalls;

    neander_mem_arbiter #(
        .MAX_WAIT(MAX_WAIT),
        .STAT_W  (STAT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_hold    (ld_hold),
        .ld_gnt     (ld_gnt),
        .ld_rvalid  (ld_rvalid),
        .ld_rdata   (ld_rdata),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_re     (ram_re),
        .ram_rdata  (ram_rdata),
        .stat_grants(stat_grants),
        .stat_stalls(stat_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: synchronous write, combinational read.
    logic [7:0] mem [256];
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic        mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_we) begin
                if (exp_wr_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ram_write: got addr 0x%0h data 0x%0h, required none",
                             ram_addr, ram_wdata);
                end else begin
                    check("ram_write", {16'h0, ram_addr, ram_wdata}, {16'h0, exp_wr_q.pop_front()});
                end
            end
            if (ld_rvalid) begin
                if (exp_rd_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ld_rvalid: got data 0x%0h, required no return",
                             ld_rdata);
                end else begin
                    check("ld_read_return", {24'h0, ld_rdata}, {24'h0, exp_rd_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        cpu_addr  = 8'h00;
        cpu_wdata = 8'h00;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        ld_req    = 1'b0;
        ld_we     = 1'b0;
        ld_addr   = 8'h00;
        ld_wdata  = 8'h00;
        ld_hold   = 1'b0;

        // Reset state.
        tick();
        tick();
        sample();
        check("rst_cpu_stall", cpu_stall, 0);
        check("rst_ld_rvalid", ld_rvalid, 0);
        check("rst_ld_rdata", ld_rdata, 0);
        check("rst_ld_gnt", ld_gnt, 0);
        check("rst_stat_grants", stat_grants, 0);
        check("rst_stat_stalls", stat_stalls, 0);

        tick();
        reset  = 1'b1;
        mon_en = 1'b1;
        sample();

        // Idle CPU: loader write then read-back.
        tick();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h80; ld_wdata = 8'h5A;
        exp_wr_q.push_back(16'h805A);
        sample();
        check("idle_wr_gnt", ld_gnt, 1);
        check("idle_wr_ram_we", ram_we, 1);
        check("idle_wr_ram_addr", ram_addr, 8'h80);
        check("idle_wr_stall", cpu_stall, 0);
        tick();
        ld_we = 1'b0;
        exp_rd_q.push_back(8'h5A);
        sample();
        check("idle_rd_gnt", ld_gnt, 1);
        check("idle_rd_ram_re", ram_re, 1);
        check("idle_rd_ram_we", ram_we, 0);
        tick();
        ld_req = 1'b0;
        sample();
        check("idle_rd_rvalid", ld_rvalid, 1);
        check("idle_rd_rdata", ld_rdata, 8'h5A);
        tick();
        sample();
        check("idle_rvalid_drop", ld_rvalid, 0);

        // Bulk load: 10 loader writes under ld_hold, frozen CPU holds a write strobe.
        tick();
        ld_hold = 1'b1; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h00; ld_wdata = 8'hA0;
        exp_wr_q.push_back(16'h00A0);
        sample();
        check("bulk_first_stall", cpu_stall, 0);
        check("bulk_first_gnt", ld_gnt, 1);
        for (int i = 1; i < 10; i++) begin
            tick();
            cpu_write = 1'b1; cpu_addr = 8'hF0; cpu_wdata = 8'hEE;
            ld_addr  = 8'(i);
            ld_wdata = 8'(8'hA0 + i);
            exp_wr_q.push_back({8'(i), 8'(8'hA0 + i)});
            sample();
            check("bulk_stall", cpu_stall, 1);
            check("bulk_gnt", ld_gnt, 1);
        end
        tick();
        ld_hold = 1'b0; ld_req = 1'b0;
        sample();
        check("bulk_fall_stall", cpu_stall, 1);
        check("bulk_fall_ram_we", ram_we, 0);
        tick();
        cpu_write = 1'b0;
        sample();
        check("bulk_resume_stall", cpu_stall, 0);

        // Starvation: CPU reads every cycle, loader read waits.
        tick();
        cpu_read = 1'b1; cpu_addr = 8'h02;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h80;
        for (int i = 0; i < 4; i++) begin
            sample();
            check("starve_stall", cpu_stall, 0);
            check("starve_gnt", ld_gnt, 0);
            check("starve_ram_addr", ram_addr, 8'h02);
            check("starve_cpu_rdata", cpu_rdata, 8'hA2);
            tick();
        end
        exp_rd_q.push_back(8'h5A);
        sample();
        check("slot_stall", cpu_stall, 1);
        check("slot_gnt", ld_gnt, 1);
        check("slot_ram_addr", ram_addr, 8'h80);
        check("slot_ram_re", ram_re, 1);
        tick();
        ld_req = 1'b0;
        sample();
        check("slot_resume_stall", cpu_stall, 0);
        check("slot_resume_ram_addr", ram_addr, 8'h02);
        tick();
        cpu_read = 1'b0;
        sample();

        // Contention: CPU write wins; refusal counts toward the forced slot.
        tick();
        cpu_write = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'h33;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 8'h20; ld_wdata = 8'h44;
        exp_wr_q.push_back(16'h1033);
        sample();
        check("cont_ram_addr", ram_addr, 8'h10);
        check("cont_ram_wdata", ram_wdata, 8'h33);
        check("cont_gnt", ld_gnt, 0);
        tick();
        cpu_write = 1'b0; cpu_read = 1'b1; cpu_addr = 8'h11;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("cont_wait_stall", cpu_stall, 0);
            check("cont_wait_gnt", ld_gnt, 0);
            tick();
        end
        exp_wr_q.push_back(16'h2044);
        sample();
        check("cont_slot_stall", cpu_stall, 1);
        check("cont_slot_gnt", ld_gnt, 1);
        check("cont_slot_ram_addr", ram_addr, 8'h20);
        tick();
        ld_req = 1'b0; ld_we = 1'b0; cpu_read = 1'b0;
        sample();
        check("cont_resume_stall", cpu_stall, 0);

        // Reset while halted with a granted read: the read return is discarded.
        tick();
        ld_hold = 1'b1;
        sample();
        check("rhalt_enter_stall", cpu_stall, 0);
        tick();
        reset = 1'b0; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 8'h05;
        sample();
        check("rhalt_stall", cpu_stall, 1);
        check("rhalt_gnt", ld_gnt, 1);
        tick();
        reset = 1'b1; ld_hold = 1'b0; ld_req = 1'b0;
        sample();
        check("rhalt_after_stall", cpu_stall, 0);
        check("rhalt_after_rvalid", ld_rvalid, 0);
        check("rhalt_after_rdata", ld_rdata, 0);

        // Statistics: 20 loader grants, then 3 stall cycles.
        for (int i = 0; i < 20; i++) begin
            tick();
            ld_req = 1'b1; ld_we = 1'b0;
            ld_addr = (i % 2 == 1) ? 8'h03 : 8'h80;
            exp_rd_q.push_back((i % 2 == 1) ? 8'hA3 : 8'h5A);
            sample();
            check("stat_gnt", ld_gnt, 1);
        end
        tick();
        ld_req = 1'b0; ld_hold = 1'b1;
        sample();
        tick();
        sample();
        check("stat_hold_stall", cpu_stall, 1);
        tick();
        sample();
        check("stat_hold_stall", cpu_stall, 1);
        tick();
        ld_hold = 1'b0;
        sample();
        check("stat_hold_fall_stall", cpu_stall, 1);
        tick();
        sample();
        check("stat_hold_end_stall", cpu_stall, 0);
`ifdef NEANDER_MEM_ARB_STATS_EN
        check("stat_grants_sat", stat_grants, 4'hF);
        check("stat_stalls", stat_stalls, 3);
`else
        check("stat_grants_off", stat_grants, 0);
        check("stat_stalls_off", stat_stalls, 0);
`endif

        tick();
        sample();
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
